// File: rtl/multibyte_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : multibyte_add_seq (with helper adder_8bit)
// Purpose  : Multi-precision add, one byte per clock through one 8-bit adder.
//            Optional subtract mode enabled by defining SUBTRACT_EN.
// Revision : 1.0  initial release
// ============================================================================

module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow
);
    logic [8:0] w_carry;

    assign w_carry[0] = carry_in;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
    end

    assign overflow = w_carry[8];
endmodule

module multibyte_add_seq #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] op_a,
    input  logic [8*NUM_BYTES-1:0] op_b,
    input  logic                   carry_in,
    input  logic                   sub,
    output logic                   busy,
    output logic                   done,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   carry_out
);
    localparam int                 c_IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BYTES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic                          w_accept;
    logic                          w_last;
    logic [c_IDX_W-1:0]            r_idx;
    logic                          r_carry;
    logic                          r_carry_out;
    logic [NUM_BYTES-1:0][7:0]     r_op_a;
    logic [NUM_BYTES-1:0][7:0]     r_op_b;
    logic [NUM_BYTES-1:0][7:0]     r_result;
    logic [8*NUM_BYTES-1:0]        w_op_b_load;
    logic                          w_carry_load;
    logic [7:0]                    w_sum;
    logic                          w_cout;

`ifdef SUBTRACT_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign w_op_b_load  = sub ? ~op_b : op_b;
    assign w_carry_load = sub ? 1'b1  : carry_in;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_op_b_load  = op_b;
    assign w_carry_load = carry_in;
`endif

    assign w_last = (r_idx == c_LAST_IDX);

    adder_8bit u_adder (
        .a        (r_op_a[r_idx]),
        .b        (r_op_b[r_idx]),
        .carry_in (r_carry),
        .sum      (w_sum),
        .overflow (w_cout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ADD;
                end
            end
            S_ADD: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
        end else if (w_accept) begin
            r_op_a      <= op_a;
            r_op_b      <= w_op_b_load;
            r_carry     <= w_carry_load;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else if (r_state == S_ADD) begin
            r_result[r_idx] <= w_sum;
            r_carry         <= w_cout;
            // Index parks on the last byte; it is cleared by the next accept.
            if (w_last) begin
                r_carry_out <= w_cout;
            end else begin
                r_idx <= r_idx + c_IDX_ONE;
            end
        end
    end

    assign busy      = (r_state == S_ADD) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_multibyte_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multibyte_add_seq
// Purpose  : Directed, model-checked bench for multibyte_add_seq (4 bytes).
// Revision : 1.0  initial release
// ============================================================================

module tb_multibyte_add_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    int checks   = 0;
    int failures = 0;

    multibyte_add_seq #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .sub       (sub),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: full-width arithmetic, bytes revealed one per ADD edge.
    logic         m_active;
    logic         m_done;
    int           m_written;
    logic [W:0]   m_full;
    logic         m_cout;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_active  <= 1'b0;
            m_done    <= 1'b0;
            m_written <= 0;
            m_full    <= '0;
            m_cout    <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_active) begin
            m_written <= m_written + 1;
            if (m_written == NB - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                m_cout   <= m_full[W];
            end
        end else if (start) begin
            m_active  <= 1'b1;
            m_written <= 0;
            m_cout    <= 1'b0;
`ifdef SUBTRACT_EN
            if (sub)
                m_full <= {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
            else
                m_full <= {1'b0, op_a} + {1'b0, op_b} + (W+1)'(carry_in);
`else
            m_full <= {1'b0, op_a} + {1'b0, op_b} + (W+1)'(carry_in);
`endif
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        logic [W-1:0] exp_res;
        exp_res = '0;
        for (int i = 0; i < NB; i++)
            if (i < m_written) exp_res[8*i +: 8] = m_full[8*i +: 8];
        check("model_busy",  W'(busy),      W'(m_active || m_done));
        check("model_done",  W'(done),      W'(m_done));
        check("model_result", result,       exp_res);
        check("model_cout",  W'(carry_out), W'(m_cout));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: pulse start, wait for done, check latency and literals.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s,
                          input logic [W-1:0] exp_res, input logic exp_cout);
        int n;
        op_a = a; op_b = b; carry_in = ci; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: done not seen in %0d cycles", name, n);
        end else begin
            check({name, "_latency"}, W'(n), W'(4));
            check({name, "_result"}, result, exp_res);
            check({name, "_cout"}, W'(carry_out), W'(exp_cout));
        end
        tick();
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int t;
        int done_t[3];
        int nd;
        logic [W-1:0] bb_a[3];
        logic [W-1:0] bb_b[3];
        logic [W-1:0] bb_r[3];
        logic         bb_c[3];

        n_rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; sub = 1'b0;
        tick();
        tick();
        check("reset_busy",   W'(busy),      '0);
        check("reset_done",   W'(done),      '0);
        check("reset_result", result,        '0);
        check("reset_cout",   W'(carry_out), '0);
        n_rst = 1'b1;
        tick();

        // Reset in the middle of an operation
        op_a = 32'h12345678; op_b = 32'h11111111; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check("midrst_busy",   W'(busy),      '0);
        check("midrst_done",   W'(done),      '0);
        check("midrst_result", result,        '0);
        check("midrst_cout",   W'(carry_out), '0);
        tick();
        n_rst = 1'b1;
        tick();

        run_op("basic",   32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);
        run_op("ripple",  32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0);
        run_op("wrap",    32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1);
        check("hold_result", result, 32'h00000000);
        check("hold_cout",   W'(carry_out), W'(1));

        // Start pulse during ADD must be ignored
        op_a = 32'h01020304; op_b = 32'h10203040; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = done ? 1 : 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                op_a = 32'hDEADBEEF; op_b = 32'hCAFEF00D; start = 1'b1;
            end
            if (i == 1) start = 1'b0;
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                check("busy_ignore_result", result, 32'h11223344);
            end
        end
        check("busy_ignore_busycnt", W'(busy_cnt), W'(5));
        check("busy_ignore_donecnt", W'(done_cnt), W'(1));

        // Back-to-back with start held high
        bb_a[0] = 32'h00000001; bb_b[0] = 32'h00000002; bb_r[0] = 32'h00000003; bb_c[0] = 1'b0;
        bb_a[1] = 32'hFFFFFFFF; bb_b[1] = 32'h00000001; bb_r[1] = 32'h00000000; bb_c[1] = 1'b1;
        bb_a[2] = 32'h0F0F0F0F; bb_b[2] = 32'h01010101; bb_r[2] = 32'h10101010; bb_c[2] = 1'b0;
        op_a = bb_a[0]; op_b = bb_b[0]; carry_in = 1'b0; start = 1'b1;
        nd = 0;
        t = 0;
        while (nd < 3 && t < 40) begin
            tick();
            t++;
            if (done) begin
                done_t[nd] = t;
                check("b2b_result", result, bb_r[nd]);
                check("b2b_cout", W'(carry_out), W'(bb_c[nd]));
                nd++;
                if (nd < 3) begin
                    op_a = bb_a[nd]; op_b = bb_b[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (nd < 3) begin
            failures++;
            $display("FAIL b2b_timeout: only %0d done pulses", nd);
        end else begin
            check("b2b_gap1", W'(done_t[1] - done_t[0]), W'(6));
            check("b2b_gap2", W'(done_t[2] - done_t[1]), W'(6));
        end
        tick();
        tick();
        tick();

`ifdef SUBTRACT_EN
        run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
        run_op("sub_ok",     32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1);
`else
        run_op("sub_ignored", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'h0000000C, 1'b0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multibyte_add_seq.md
# multibyte_add_seq

Sequential multi-precision adder controller: sums two NUM_BYTES-byte operands by time-sharing a single `adder_8bit` instance, one byte per clock, least-significant byte first, chaining the carry through a register. It sits between a requester issuing start/operand handshakes and the existing 8-bit ripple-carry adder datapath. It produces a registered full-width result, a final carry-out, and a one-cycle done pulse.

## Interface
- NUM_BYTES, default 4: operand width in bytes; legal range 2–16.
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  8*NUM_BYTES  operand A; captured on accepted start
- op_b  input  8*NUM_BYTES  operand B; captured on accepted start
- carry_in  input  1  initial carry into byte 0; captured on accepted start
- sub  input  1  subtract request; captured on accepted start (used only with SUBTRACT_EN)
- busy  output  1  high in ADD and DONE states
- done  output  1  one-cycle pulse, result valid
- result  output  8*NUM_BYTES  registered sum
- carry_out  output  1  registered carry out of the most-significant byte

## Operation
- Exactly one `adder_8bit` is instantiated. Its a/b/carry_in inputs are driven from the operand registers selected by the byte index and from the carry register. Its sum/overflow outputs are the byte sum and carry.
- State machine:
  - IDLE: start=1 → capture op_a, op_b, carry_in, and sub into internal registers; clear the byte index to 0; go to ADD. start=0 → stay in IDLE.
  - ADD: write the byte sum into result[8*idx +: 8] and the adder carry into the carry register. If idx==NUM_BYTES-1, go to DONE; otherwise idx+1.
  - DONE: assert done; go to IDLE unconditionally.
- start is ignored while busy. No queuing and no error flag.
- result and carry_out hold their values from the end of the operation until the next accepted start.
- On an accepted start, result clears to 0 and carry_out clears to 0.
- carry_out equals the carry register after the final ADD cycle.
- Arithmetic is unsigned modulo 2^(8*NUM_BYTES).
- The byte-index counter width is clog2(NUM_BYTES). It never wraps past NUM_BYTES-1.
- Reset, including mid-operation, asynchronously forces: state IDLE, idx 0, carry register 0, operand registers 0, result 0, carry_out 0, busy 0, done 0. The partial operation is discarded.

## Timing
- Accepting start at edge k gives ADD cycles k+1 … k+NUM_BYTES.
- done is high for exactly one cycle, between edges k+NUM_BYTES and k+NUM_BYTES+1.
- Latency from accepted start to done is NUM_BYTES+1 edges. With NUM_BYTES=4, start sampled at edge 0 gives done high after edge 4.
- busy rises the cycle after start is accepted and falls together with done.
- A new start may be accepted at the edge where the FSM returns to IDLE, i.e. the first edge at which done is low.
- Back-to-back throughput is one operation per NUM_BYTES+2 cycles.
- start held high continuously is accepted again on each IDLE visit.
- carry_out is valid when done is high.

## Configuration
- SUBTRACT_EN defined:
  - At capture with sub=1: the op_b register loads ~op_b, and the carry register loads 1. carry_in is ignored.
  - Result is op_a − op_b mod 2^(8*NUM_BYTES).
  - carry_out=1 means no borrow (op_a ≥ op_b).
- SUBTRACT_EN undefined:
  - The sub port still exists but is ignored. Addition only.
  - No inversion logic is generated.

## Test plan
- Reset mid-op, NUM_BYTES=4: start with op_a=0x12345678, reset asserted after 2 ADD cycles → all outputs 0 immediately, state IDLE. Start after release completes normally.
- Basic add: op_a=0x12345678, op_b=0x11111111, carry_in=0 → done 5 edges after start, result=0x23456789, carry_out=0.
- Carry ripple across bytes: op_a=0x00FFFFFF, op_b=0x00000001, carry_in=0 → result=0x01000000, carry_out=0. Then op_a=0xFFFFFFFF, op_b=0x00000000, carry_in=1 → result=0x00000000, carry_out=1.
- Start while busy: second start pulse with different operands during ADD → ignored. done pulses once, result from the first operands only. busy high 5 cycles.
- Back-to-back: start held high for 3 operations → 3 done pulses spaced 6 cycles apart, each result correct.
- SUBTRACT_EN: op_a=0x00000005, op_b=0x00000007, sub=1 → result=0xFFFFFFFE, carry_out=0. op_a=7, op_b=5 → result=0x00000002, carry_out=1.
